// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle DIV sequencer.
package div_pkg;

  localparam int DEF_REG_SIZE = 32;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_REG_SIZE);

  localparam logic [DEF_REG_SIZE-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One non-restoring shift-subtract iteration on {P,Q} against divisor magnitude D.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   p,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   p_next,
  output logic [W-1:0] q_next
);

  logic [W:0] p_sh;

  // P is one bit wider than D, so the top bit dropped by the shift is pure
  // sign information and the modular add/sub still lands in [-D, D).
  assign p_sh   = {p[W-1:0], q[W-1]};
  assign p_next = p[W] ? p_sh + {1'b0, d} : p_sh - {1'b0, d};
  assign q_next = {q[W-2:0], ~p_next[W]};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divider: latch, PREP, REG_SIZE iterations, FIX, DONE.
module div_sequencer
  import div_pkg::*;
#(
  parameter int REG_SIZE = DEF_REG_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                is_signed,
  input  logic [REG_SIZE-1:0] dividend,
  input  logic [REG_SIZE-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [REG_SIZE-1:0] quotient,
  output logic [REG_SIZE-1:0] remainder,
  output logic                div_by_zero
);

  localparam int CW = cnt_width(REG_SIZE);
  localparam logic [CW-1:0] LAST = CW'(REG_SIZE - 1);
  localparam logic [REG_SIZE-1:0] DZ_Q = {REG_SIZE{DZ_QUOTIENT[0]}};

  state_t state, state_nx;

  logic [CW-1:0]       count;
  logic [REG_SIZE-1:0] a_raw, b_raw, d_r, q_r;
  logic [REG_SIZE:0]   p_r;
  logic                neg_a, neg_b;

  logic [REG_SIZE-1:0] a_mag, b_mag, q_step;
  logic [REG_SIZE:0]   p_step, p_fix;

  div_step #(.W(REG_SIZE)) u_step (
    .p      (p_r),
    .q      (q_r),
    .d      (d_r),
    .p_next (p_step),
    .q_next (q_step)
  );

  // neg_a/neg_b already include is_signed, so unsigned operands pass through raw.
  assign a_mag = neg_a ? -a_raw : a_raw;
  assign b_mag = neg_b ? -b_raw : b_raw;
  assign p_fix = p_r[REG_SIZE] ? p_r + {1'b0, d_r} : p_r;

  assign busy = (state == PREP) || (state == ITER) || (state == FIX);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: state_nx is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = PREP;
      DONE:    state_nx = start ? PREP : IDLE;
      PREP:    state_nx = (b_raw == '0) ? FIX : ITER;
      ITER:    if (count == LAST) state_nx = FIX;
      FIX:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, not just the control state, so a
  // reset mid-divide leaves no stale operands or results visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      a_raw       <= '0;
      b_raw       <= '0;
      d_r         <= '0;
      q_r         <= '0;
      p_r         <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_raw <= dividend;
            b_raw <= divisor;
            neg_a <= is_signed & dividend[REG_SIZE-1];
            neg_b <= is_signed & divisor[REG_SIZE-1];
          end
        end
        PREP: begin
          d_r   <= b_mag;
          p_r   <= '0;
          q_r   <= a_mag;
          count <= '0;
        end
        ITER: begin
          p_r   <= p_step;
          q_r   <= q_step;
          count <= count + CW'(1);
        end
        FIX: begin
          if (b_raw == '0) begin
            quotient    <= DZ_Q;
            remainder   <= a_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= (neg_a ^ neg_b) ? -q_r : q_r;
            remainder   <= neg_a ? -p_fix[REG_SIZE-1:0] : p_fix[REG_SIZE-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
